bus_cycle_scheduler: RTL and testbench

Master-clock bus-cycle scheduler for the Atari core. Divides the fast system clock into 6502 bus cycles (phi1/phi2 enables plus a phi0 level), tracks horizontal position in 114-cycle scan lines, and arbitrates each bus cycle between the CPU and ANTIC DMA. It also stalls the CPU on WSYNC. Every CPU/ANTIC/GTIA register update is gated by its enables, so the whole core runs on one clock with no derived clocks.

---
 rtl/atari_clk_pkg.sv | 40 ++++
 rtl/bus_cycle_scheduler_if.sv | 38 +++
 rtl/phase_gen.sv | 28 ++
 rtl/bus_cycle_scheduler.sv | 98 +++++++++
 tb/tb_bus_cycle_scheduler.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/atari_clk_pkg.sv
// Shared types and constants for the Atari master-clock bus-cycle scheduler.
package atari_clk_pkg;

  localparam int unsigned LINE_CYCLES_NTSC  = 114;
  localparam int unsigned WSYNC_POS_DEFAULT = 104;
  localparam int unsigned HPOS_W            = 7;

  typedef enum logic [1:0] {
    OWN_CPU   = 2'd0,
    OWN_DEFER = 2'd1,
    OWN_DMA   = 2'd2,
    OWN_WSYNC = 2'd3
  } owner_e;

  // Bus-cycle owner for the cycle starting at this phi1_en; DMA > WSYNC > CPU.
  function automatic owner_e next_owner(input owner_e cur, input logic dma_req,
                                        input logic cpu_rw, input logic pend,
                                        input logic at_release);
    case (cur)
      OWN_CPU: begin
        if (dma_req)            return cpu_rw ? OWN_DMA : OWN_DEFER;
        else if (pend && cpu_rw) return OWN_WSYNC;
        else                    return OWN_CPU;
      end
      OWN_DEFER: return cpu_rw ? OWN_DMA : OWN_DEFER;
      OWN_DMA: begin
        if (dma_req)   return OWN_DMA;
        else if (pend) return OWN_WSYNC;
        else           return OWN_CPU;
      end
      OWN_WSYNC: begin
        if (dma_req)         return OWN_DMA;
        else if (at_release) return OWN_CPU;
        else                 return OWN_WSYNC;
      end
      default: return OWN_CPU;
    endcase
  endfunction

endpackage

// File: rtl/bus_cycle_scheduler_if.sv
// Bus-cycle scheduler signal bundle; SCHED_STATS_EN adds the stolen/stall counters.
interface bus_cycle_scheduler_if;
  import atari_clk_pkg::*;

  logic              run;
  logic              dma_req;
  logic              cpu_rw;
  logic              wsync;
  logic              phi0;
  logic              phi1_en;
  logic              phi2_en;
  logic              cpu_en;
  logic              dma_gnt;
  logic              cpu_rdy;
  logic [HPOS_W-1:0] hpos;
  logic              line_start;
`ifdef SCHED_STATS_EN
  logic [15:0]       stolen_cnt;
  logic [15:0]       stall_cnt;
`endif

  modport master (
    input  run, dma_req, cpu_rw, wsync,
    output phi0, phi1_en, phi2_en, cpu_en, dma_gnt, cpu_rdy, hpos, line_start
`ifdef SCHED_STATS_EN
    , output stolen_cnt, stall_cnt
`endif
  );

  modport slave (
    output run, dma_req, cpu_rw, wsync,
    input  phi0, phi1_en, phi2_en, cpu_en, dma_gnt, cpu_rdy, hpos, line_start
`ifdef SCHED_STATS_EN
    , input stolen_cnt, stall_cnt
`endif
  );

endinterface

// File: rtl/phase_gen.sv
// Divides clkin into 6502 bus-cycle phases: master counter, phi0 level, phi1/phi2 enables.
module phase_gen #(
  parameter int unsigned DIVIDE = 16,
  parameter int unsigned MW     = $clog2(DIVIDE)
) (
  input  logic          clkin,
  input  logic          RST,
  input  logic          run,
  output logic [MW-1:0] m,
  output logic          phi0,
  output logic          phi1_en,
  output logic          phi2_en
);

  localparam logic [MW-1:0] M_LAST = MW'(DIVIDE - 1);
  localparam logic [MW-1:0] M_HALF = MW'(DIVIDE / 2);

  always_ff @(posedge clkin) begin
    if (RST)      m <= '0;
    else if (run) m <= (m == M_LAST) ? '0 : m + MW'(1);
  end

  // Enables are gated by RST so an abandoned cycle leaves no trailing pulse.
  assign phi1_en = run & ~RST & (m == '0);
  assign phi2_en = run & ~RST & (m == M_HALF);
  assign phi0    = ~RST & (m >= M_HALF);

endmodule

// File: rtl/bus_cycle_scheduler.sv
// Bus-cycle scheduler: phase generation, scan-line position, CPU/ANTIC DMA/WSYNC ownership.
// Optional SCHED_STATS_EN adds saturating stolen/stall cycle counters.
module bus_cycle_scheduler
  import atari_clk_pkg::*;
#(
  parameter int unsigned DIVIDE      = 16,
  parameter int unsigned LINE_CYCLES = LINE_CYCLES_NTSC,
  parameter int unsigned WSYNC_POS   = WSYNC_POS_DEFAULT
) (
  input  logic                  clkin,
  input  logic                  RST,
  bus_cycle_scheduler_if.master bus
);

  localparam int unsigned MW = $clog2(DIVIDE);

  logic [MW-1:0]     m;
  logic              phi0;
  logic              phi1_en;
  logic              phi2_en;
  logic [HPOS_W-1:0] hpos;
  owner_e            owner;
  owner_e            owner_nxt;
  logic              pend;
  logic              pend_now;
  logic              at_release;
  logic              cyc_end;
  logic              dma_gnt;
  logic              cpu_rdy;

  phase_gen #(.DIVIDE(DIVIDE), .MW(MW)) u_phase_gen (
    .clkin   (clkin),
    .RST     (RST),
    .run     (bus.run),
    .m       (m),
    .phi0    (phi0),
    .phi1_en (phi1_en),
    .phi2_en (phi2_en)
  );

  // hpos advances on the last clkin of a bus cycle so it names the cycle at its phi1_en.
  assign cyc_end = bus.run & (m == MW'(DIVIDE - 1));

  always_ff @(posedge clkin) begin
    if (RST)          hpos <= '0;
    else if (cyc_end) hpos <= (hpos == HPOS_W'(LINE_CYCLES - 1)) ? '0 : hpos + HPOS_W'(1);
  end

  // A wsync pulse coincident with phi1_en counts for that decision.
  assign pend_now   = pend | bus.wsync;
  assign at_release = (hpos == HPOS_W'(WSYNC_POS));
  assign owner_nxt  = next_owner(owner, bus.dma_req, bus.cpu_rw, pend_now, at_release);

  always_ff @(posedge clkin) begin
    if (RST) begin
      owner   <= OWN_CPU;
      pend    <= 1'b0;
      dma_gnt <= 1'b0;
      cpu_rdy <= 1'b1;
    end else begin
      if (phi1_en) begin
        owner   <= owner_nxt;
        dma_gnt <= (owner_nxt == OWN_DMA);
        cpu_rdy <= (owner_nxt == OWN_CPU);
        if (owner == OWN_WSYNC && owner_nxt == OWN_CPU) pend <= 1'b0;
      end
      if (bus.wsync) pend <= 1'b1;
    end
  end

  assign bus.phi0       = phi0;
  assign bus.phi1_en    = phi1_en;
  assign bus.phi2_en    = phi2_en;
  assign bus.cpu_en     = phi2_en & ((owner == OWN_CPU) | (owner == OWN_DEFER));
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_rdy    = cpu_rdy;
  assign bus.hpos       = hpos;
  assign bus.line_start = phi1_en & (hpos == '0);

`ifdef SCHED_STATS_EN
  logic [15:0] stolen_cnt;
  logic [15:0] stall_cnt;

  always_ff @(posedge clkin) begin
    if (RST) begin
      stolen_cnt <= '0;
      stall_cnt  <= '0;
    end else if (phi1_en) begin
      if (owner_nxt == OWN_DMA && stolen_cnt != 16'hFFFF)  stolen_cnt <= stolen_cnt + 16'd1;
      if (owner_nxt == OWN_WSYNC && stall_cnt != 16'hFFFF) stall_cnt  <= stall_cnt + 16'd1;
    end
  end

  assign bus.stolen_cnt = stolen_cnt;
  assign bus.stall_cnt  = stall_cnt;
`endif

endmodule

// File: tb/tb_bus_cycle_scheduler.sv
// Directed self-checking bench for bus_cycle_scheduler at DIVIDE=16 (stats checked when SCHED_STATS_EN).
module tb_bus_cycle_scheduler;

  localparam int DIV  = 16;
  localparam int LINE = 114;
  localparam int WPOS = 104;

  logic clkin = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_h  = 0;

  always #5 clkin = ~clkin;

  bus_cycle_scheduler_if bus ();

  bus_cycle_scheduler #(.DIVIDE(DIV), .LINE_CYCLES(LINE), .WSYNC_POS(WPOS)) dut (
    .clkin (clkin),
    .RST   (RST),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One bus cycle from its phi1_en window to the next; counts what each output did.
  task automatic bus_cycle(input logic dma, input logic rw, input int ws_at,
                           output int gnt_n, output int en_n, output int rdy_n,
                           output int p2_at, output int phi0_n);
    gnt_n = 0; en_n = 0; rdy_n = 0; p2_at = -1; phi0_n = 0;
    bus.dma_req = dma;
    bus.cpu_rw  = rw;
    if (ws_at == 0) bus.wsync = 1'b1;
    for (int k = 1; k <= DIV; k++) begin
      @(negedge clkin);
      if (k == 1) bus.dma_req = 1'b0;
      if (k == ws_at + 1) bus.wsync = 1'b0;
      if (k == ws_at) bus.wsync = 1'b1;
      gnt_n  += int'(bus.dma_gnt);
      en_n   += int'(bus.cpu_en);
      rdy_n  += int'(bus.cpu_rdy);
      phi0_n += int'(bus.phi0);
      if (bus.phi2_en) p2_at = (p2_at == -1) ? k : 99;
    end
    exp_h = (exp_h + 1) % LINE;
  endtask

  task automatic cyc_chk(input string tag, input logic dma, input logic rw, input int ws_at,
                         input int e_gnt, input int e_en, input int e_rdy);
    int    gnt_n, en_n, rdy_n, p2_at, phi0_n;
    string t;
    t = $sformatf("%s@%0d", tag, exp_h);
    chk({t, ".phi1"}, int'(bus.phi1_en), 1);
    chk({t, ".hpos"}, int'(bus.hpos), exp_h);
    chk({t, ".line_start"}, int'(bus.line_start), (exp_h == 0) ? 1 : 0);
    bus_cycle(dma, rw, ws_at, gnt_n, en_n, rdy_n, p2_at, phi0_n);
    chk({t, ".phi2_at"}, p2_at, DIV / 2);
    chk({t, ".phi0_n"}, phi0_n, DIV / 2);
    chk({t, ".gnt_n"}, gnt_n, e_gnt);
    chk({t, ".cpu_en_n"}, en_n, e_en);
    chk({t, ".rdy_n"}, rdy_n, e_rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    RST = 1'b1;
    bus.run = 1'b1; bus.dma_req = 1'b0; bus.cpu_rw = 1'b1; bus.wsync = 1'b0;
    repeat (3) @(negedge clkin);
    chk("rst.phi1", int'(bus.phi1_en), 0);
    chk("rst.phi0", int'(bus.phi0), 0);
    chk("rst.hpos", int'(bus.hpos), 0);
    chk("rst.gnt", int'(bus.dma_gnt), 0);
    chk("rst.rdy", int'(bus.cpu_rdy), 1);
    chk("rst.cpu_en", int'(bus.cpu_en), 0);
`ifdef SCHED_STATS_EN
    chk("rst.stolen", int'(bus.stolen_cnt), 0);
    chk("rst.stall", int'(bus.stall_cnt), 0);
`endif
    RST = 1'b0;
    #1;
    chk("first.phi1", int'(bus.phi1_en), 1);
    chk("first.line_start", int'(bus.line_start), 1);

    // Free run across a line wrap.
    for (int i = 0; i < LINE + 2; i++) cyc_chk("free", 1'b0, 1'b1, -1, 0, 1, 16);

    // Three DMA read cycles.
    repeat (3) cyc_chk("dma", 1'b1, 1'b1, -1, 16, 0, 0);
    cyc_chk("dma_end", 1'b0, 1'b1, -1, 0, 1, 16);

    // DMA requested during CPU writes is deferred.
    repeat (2) cyc_chk("defer", 1'b1, 1'b0, -1, 0, 1, 0);
    cyc_chk("defer_dma", 1'b1, 1'b1, -1, 16, 0, 0);
    cyc_chk("defer_end", 1'b0, 1'b1, -1, 0, 1, 16);

    // WSYNC pulse mid-cycle at hpos 10.
    while (exp_h != 10) cyc_chk("pre_ws", 1'b0, 1'b1, -1, 0, 1, 16);
    cyc_chk("ws_pulse", 1'b0, 1'b1, 3, 0, 1, 16);
    while (exp_h != WPOS) cyc_chk("ws_stall", 1'b0, 1'b1, -1, 0, 0, 0);
    cyc_chk("ws_release", 1'b0, 1'b1, -1, 0, 1, 16);

    // WSYNC on the phi1_en clkin, with a DMA cycle interleaved.
    while (exp_h != 20) cyc_chk("pre_ws2", 1'b0, 1'b1, -1, 0, 1, 16);
    cyc_chk("ws_same", 1'b0, 1'b1, 0, 0, 0, 0);
    while (exp_h != 50) cyc_chk("ws2_stall", 1'b0, 1'b1, -1, 0, 0, 0);
    cyc_chk("ws_dma", 1'b1, 1'b1, -1, 16, 0, 0);
    while (exp_h != WPOS) cyc_chk("ws2_stall", 1'b0, 1'b1, -1, 0, 0, 0);
    cyc_chk("ws2_release", 1'b0, 1'b1, -1, 0, 1, 16);
`ifdef SCHED_STATS_EN
    chk("stats.stolen", int'(bus.stolen_cnt), 5);
    chk("stats.stall", int'(bus.stall_cnt), 176);
`endif

    // run low mid DMA cycle: everything freezes, phase resumes.
    chk("freeze.entry_hpos", int'(bus.hpos), exp_h);
    bus.dma_req = 1'b1; bus.cpu_rw = 1'b1;
    @(negedge clkin); bus.dma_req = 1'b0;
    repeat (2) @(negedge clkin);
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkin);
      chk("freeze.enables", int'(bus.phi1_en | bus.phi2_en | bus.cpu_en), 0);
      chk("freeze.gnt", int'(bus.dma_gnt), 1);
      chk("freeze.hpos", int'(bus.hpos), exp_h);
      chk("freeze.phi0", int'(bus.phi0), 0);
    end
    bus.run = 1'b1;
    seen = -1;
    for (int t = 1; t <= 20 && seen < 0; t++) begin
      @(negedge clkin);
      if (bus.phi2_en) seen = t;
    end
    chk("resume.phi2_delay", seen, 5);
    seen = -1;
    for (int t = 1; t <= 20 && seen < 0; t++) begin
      @(negedge clkin);
      if (bus.phi1_en) seen = t;
    end
    chk("resume.phi1_delay", seen, 8);
    exp_h = (exp_h + 1) % LINE;
    chk("resume.gnt", int'(bus.dma_gnt), 1);
    cyc_chk("resume", 1'b0, 1'b1, -1, 0, 1, 16);

    // RST at m=5 during a DMA cycle.
    bus.dma_req = 1'b1; bus.cpu_rw = 1'b1;
    @(negedge clkin); bus.dma_req = 1'b0;
    repeat (4) @(negedge clkin);
    chk("rst_mid.gnt_before", int'(bus.dma_gnt), 1);
    RST = 1'b1;
    @(negedge clkin);
    chk("rst_mid.gnt", int'(bus.dma_gnt), 0);
    chk("rst_mid.rdy", int'(bus.cpu_rdy), 1);
    chk("rst_mid.hpos", int'(bus.hpos), 0);
    chk("rst_mid.cpu_en", int'(bus.cpu_en), 0);
`ifdef SCHED_STATS_EN
    chk("rst_mid.stolen", int'(bus.stolen_cnt), 0);
    chk("rst_mid.stall", int'(bus.stall_cnt), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid.phi_en", int'(bus.phi1_en | bus.phi2_en), 0);
      @(negedge clkin);
    end
    RST = 1'b0;
    #1;
    exp_h = 0;
    cyc_chk("post_rst", 1'b0, 1'b1, -1, 0, 1, 16);
    cyc_chk("post_rst", 1'b0, 1'b1, -1, 0, 1, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
